// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive protocol checker for the intersection controller light outputs.
// The raw light buses are registered once, decoded into one of four legal
// phases, and checked for legal encoding, phase order and phase dwell time.
// Violations are reported as one-cycle pulses, a sticky flag and an optional
// saturating error counter.
//
// Optional feature macro: TLM_ERRCNT_EN
//   defined   -> err_count is a saturating ERRCNT_W-bit counter
//   undefined -> no counter, err_count is tied to zero
//
// Parameters:
//   GREEN_DURATION  required dwell of phases 0 and 2 (clk cycles)
//   YELLOW_DURATION required dwell of phases 1 and 3 (clk cycles)
//   CNT_W           dwell counter width, must hold max duration + 1
//   ERRCNT_W        error counter width
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   highway_lights  001 green, 010 yellow, 100 red
//   country_lights  same encoding
//   phase           decoded phase: 0 HG/CR, 1 HY/CR, 2 HR/CG, 3 HR/CY
//   locked          monitor synchronised to a legal phase
//   err_illegal     pulse: sample is not one of the four legal pairs
//   err_sequence    pulse: legal phase change that was not phase+1
//   err_duration    pulse: phase too short (at exit) or too long
//   err_sticky      OR of all error pulses since reset
//   err_count       saturating count of cycles with any error pulse
//   cycle_done      pulse on an in-order phase 3 -> phase 0 change
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
   parameter int GREEN_DURATION  = 8,
   parameter int YELLOW_DURATION = 3,
   parameter int CNT_W           = 5,
   parameter int ERRCNT_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          highway_lights,
   input  logic [2:0]          country_lights,
   output logic [1:0]          phase,
   output logic                locked,
   output logic                err_illegal,
   output logic                err_sequence,
   output logic                err_duration,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_count,
   output logic                cycle_done
);

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_DURATION);
   localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_DURATION);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0] MAX_C    = '1;

   // Input stage; s_vld_q keeps the reset value of the sample registers
   // from being judged as an illegal encoding.
   logic [2:0] s_hw_q;
   logic [2:0] s_cr_q;
   logic       s_vld_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_hw_q  <= 3'b000;
         s_cr_q  <= 3'b000;
         s_vld_q <= 1'b0;
      end else begin
         s_hw_q  <= highway_lights;
         s_cr_q  <= country_lights;
         s_vld_q <= 1'b1;
      end
   end

   state_t           state_q;
   logic [1:0]       phase_q;
   logic [CNT_W-1:0] dwell_q;
   logic             partial_q;
   logic             locked_q;
   logic             err_illegal_q;
   logic             err_sequence_q;
   logic             err_duration_q;
   logic             err_sticky_q;
   logic             cycle_done_q;

   logic             legal;
   logic [1:0]       dec_phase;
   logic [CNT_W-1:0] exp_dwell;
   logic [CNT_W-1:0] dwell_inc;
   logic             illegal_d;
   logic             sequence_d;
   logic             duration_d;
   logic             done_d;
   logic             any_err_d;

   always_comb begin
      legal     = 1'b1;
      dec_phase = 2'd0;
      case ({s_hw_q, s_cr_q})
         6'b001_100: dec_phase = 2'd0;
         6'b010_100: dec_phase = 2'd1;
         6'b100_001: dec_phase = 2'd2;
         6'b100_010: dec_phase = 2'd3;
         default:    legal     = 1'b0;
      endcase

      exp_dwell = phase_q[0] ? YELLOW_C : GREEN_C;
      dwell_inc = (dwell_q == MAX_C) ? dwell_q : dwell_q + ONE_C;

      illegal_d  = 1'b0;
      sequence_d = 1'b0;
      duration_d = 1'b0;
      done_d     = 1'b0;
      if (s_vld_q) begin
         if (!legal) begin
            illegal_d = 1'b1;
         end else if (state_q == TRACK) begin
            if (dec_phase == phase_q) begin
               // Overstay fires only on the step from expected to
               // expected+1, so it can be raised once per phase.
               duration_d = !partial_q && (dwell_q == exp_dwell);
            end else if (dec_phase == phase_q + 2'd1) begin
               // A flagged overstay implies dwell > expected, so the
               // understay test below can never double-report it.
               duration_d = !partial_q && (dwell_q < exp_dwell);
               done_d     = (phase_q == 2'd3);
            end else begin
               sequence_d = 1'b1;
            end
         end
      end
      any_err_d = illegal_d | sequence_d | duration_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ACQUIRE;
         phase_q        <= 2'd0;
         dwell_q        <= '0;
         partial_q      <= 1'b1;
         locked_q       <= 1'b0;
         err_illegal_q  <= 1'b0;
         err_sequence_q <= 1'b0;
         err_duration_q <= 1'b0;
         err_sticky_q   <= 1'b0;
         cycle_done_q   <= 1'b0;
      end else begin
         err_illegal_q  <= illegal_d;
         err_sequence_q <= sequence_d;
         err_duration_q <= duration_d;
         cycle_done_q   <= done_d;
         err_sticky_q   <= err_sticky_q | any_err_d;
         if (s_vld_q) begin
            if (!legal) begin
               state_q   <= ACQUIRE;
               locked_q  <= 1'b0;
               partial_q <= 1'b1;
            end else begin
               case (state_q)
                  ACQUIRE: begin
                     // The phase we land in may already be under way,
                     // so its length cannot be judged.
                     state_q   <= TRACK;
                     locked_q  <= 1'b1;
                     phase_q   <= dec_phase;
                     dwell_q   <= ONE_C;
                     partial_q <= 1'b1;
                  end
                  TRACK: begin
                     if (dec_phase == phase_q) begin
                        dwell_q <= dwell_inc;
                     end else begin
                        phase_q   <= dec_phase;
                        dwell_q   <= ONE_C;
                        partial_q <= 1'b0;
                     end
                  end
                  default: state_q <= ACQUIRE;
               endcase
            end
         end
      end
   end

`ifdef TLM_ERRCNT_EN
   localparam logic [ERRCNT_W-1:0] ERR_ONE_C = ERRCNT_W'(1);
   logic [ERRCNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (any_err_d && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_ONE_C;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

   assign phase        = phase_q;
   assign locked       = locked_q;
   assign err_illegal  = err_illegal_q;
   assign err_sequence = err_sequence_q;
   assign err_duration = err_duration_q;
   assign err_sticky   = err_sticky_q;
   assign cycle_done   = cycle_done_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. Each driven sample is run through
// a small reference model and its expected outputs are pushed to a queue;
// entries are popped and compared two cycles later when the monitor has
// produced its response. A second instance with a 2-bit error counter shares
// the inputs for the saturation case. Scenario-level totals are also checked
// against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

   localparam int G_LEN = 8;
   localparam int Y_LEN = 3;
`ifdef TLM_ERRCNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic       clk;
   logic       reset;
   logic [2:0] hw_l;
   logic [2:0] cr_l;

   logic [1:0] phase_o;
   logic       locked_o, ill_o, seq_o, dur_o, sticky_o, done_o;
   logic [7:0] cnt_o;

   logic [1:0] s_phase;
   logic       s_locked, s_ill, s_seq, s_dur, s_sticky, s_done;
   logic [1:0] s_cnt;

   traffic_light_monitor u_dut (
      .clk            (clk),
      .reset          (reset),
      .highway_lights (hw_l),
      .country_lights (cr_l),
      .phase          (phase_o),
      .locked         (locked_o),
      .err_illegal    (ill_o),
      .err_sequence   (seq_o),
      .err_duration   (dur_o),
      .err_sticky     (sticky_o),
      .err_count      (cnt_o),
      .cycle_done     (done_o)
   );

   traffic_light_monitor #(.ERRCNT_W(2)) u_sat (
      .clk            (clk),
      .reset          (reset),
      .highway_lights (hw_l),
      .country_lights (cr_l),
      .phase          (s_phase),
      .locked         (s_locked),
      .err_illegal    (s_ill),
      .err_sequence   (s_seq),
      .err_duration   (s_dur),
      .err_sticky     (s_sticky),
      .err_count      (s_cnt),
      .cycle_done     (s_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0] phase;
      logic       locked;
      logic       ill;
      logic       seq;
      logic       dur;
      logic       done;
      logic       sticky;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // observed pulse totals for the current scenario
   int ill_seen, seq_seen, dur_seen, done_seen;

   // reference model state
   int m_phase, m_run, m_cnt8, m_cnt2;
   bit m_locked, m_partial, m_ovr, m_sticky;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      assert (obs === req) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
   endtask

   function automatic int decode(input logic [2:0] hw, input logic [2:0] cr);
      case ({hw, cr})
         6'b001100: return 0;
         6'b010100: return 1;
         6'b100001: return 2;
         6'b100010: return 3;
         default:   return -1;
      endcase
   endfunction

   function automatic int exp_len(input int p);
      return (p % 2 == 1) ? Y_LEN : G_LEN;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_locked = 0; m_partial = 1; m_ovr = 0; m_sticky = 0;
   endtask

   task automatic model_step(input logic [2:0] hw, input logic [2:0] cr, output exp_t e);
      int p;
      e.ill = 0; e.seq = 0; e.dur = 0; e.done = 0;
      p = decode(hw, cr);
      if (p < 0) begin
         e.ill = 1; m_locked = 0; m_partial = 1;
      end else if (!m_locked) begin
         m_locked = 1; m_phase = p; m_run = 1; m_partial = 1; m_ovr = 0;
      end else if (p == m_phase) begin
         if (m_run < 31) m_run++;
         if (!m_partial && !m_ovr && m_run == exp_len(m_phase) + 1) begin
            e.dur = 1; m_ovr = 1;
         end
      end else if (p == (m_phase + 1) % 4) begin
         if (!m_partial && !m_ovr && m_run < exp_len(m_phase)) e.dur = 1;
         if (m_phase == 3) e.done = 1;
         m_phase = p; m_run = 1; m_partial = 0; m_ovr = 0;
      end else begin
         e.seq = 1;
         m_phase = p; m_run = 1; m_partial = 0; m_ovr = 0;
      end
      if (e.ill || e.seq || e.dur) begin
         m_sticky = 1;
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      e.phase  = 2'(m_phase);
      e.locked = m_locked;
      e.sticky = m_sticky;
      e.cnt    = (CNT_ON == 1) ? 8'(m_cnt8) : 8'd0;
      e.cnt2   = (CNT_ON == 1) ? 2'(m_cnt2) : 2'd0;
   endtask

   task automatic pop_one();
      exp_t e;
      e = sb_q.pop_front();
      $display("t=%0t phase=%0d locked=%0b ill=%0b seq=%0b dur=%0b done=%0b sticky=%0b cnt=%0d",
               $time, phase_o, locked_o, ill_o, seq_o, dur_o, done_o, sticky_o, cnt_o);
      chk("phase",        phase_o,  e.phase);
      chk("locked",       locked_o, e.locked);
      chk("err_illegal",  ill_o,    e.ill);
      chk("err_sequence", seq_o,    e.seq);
      chk("err_duration", dur_o,    e.dur);
      chk("cycle_done",   done_o,   e.done);
      chk("err_sticky",   sticky_o, e.sticky);
      chk("err_count",    cnt_o,    e.cnt);
      chk("err_count_w2", s_cnt,    e.cnt2);
      ill_seen  += int'(ill_o);
      seq_seen  += int'(seq_o);
      dur_seen  += int'(dur_o);
      done_seen += int'(done_o);
   endtask

   task automatic tick(input logic [2:0] hw, input logic [2:0] cr);
      exp_t e;
      @(negedge clk);
      if (sb_q.size() >= 2) pop_one();
      reset = 1'b0;
      hw_l  = hw;
      cr_l  = cr;
      model_step(hw, cr, e);
      sb_q.push_back(e);
   endtask

   task automatic run(input int p, input int n);
      logic [2:0] hw, cr;
      case (p)
         0:       begin hw = 3'b001; cr = 3'b100; end
         1:       begin hw = 3'b010; cr = 3'b100; end
         2:       begin hw = 3'b100; cr = 3'b001; end
         default: begin hw = 3'b100; cr = 3'b010; end
      endcase
      repeat (n) tick(hw, cr);
   endtask

   task automatic rot(input int n);
      repeat (n) begin
         run(0, G_LEN); run(1, Y_LEN); run(2, G_LEN); run(3, Y_LEN);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_phase"},  phase_o,  0);
      chk({tag, "_locked"}, locked_o, 0);
      chk({tag, "_pulses"}, {ill_o, seq_o, dur_o, done_o}, 0);
      chk({tag, "_sticky"}, sticky_o, 0);
      chk({tag, "_count"},  cnt_o,    0);
   endtask

   task automatic reset_on();
      reset = 1'b1;
      sb_q.delete();
      model_reset();
      #1;
      check_zero("rst_assert");
   endtask

   task automatic hold_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
   endtask

   task automatic begin_scn(input string name);
      $display("scenario %s", name);
      ill_seen = 0; seq_seen = 0; dur_seen = 0; done_seen = 0;
      reset_on();
      hold_reset(2);
   endtask

   task automatic end_scn();
      repeat (2) begin
         @(negedge clk);
         if (sb_q.size() > 0) pop_one();
      end
   endtask

   initial begin
      reset = 1'b0;
      hw_l  = 3'b000;
      cr_l  = 3'b000;
      #1;

      // Nominal: three rotations from joint reset
      begin_scn("nominal");
      rot(3);
      end_scn();
      chk("nominal_done_total", done_seen, 2);
      chk("nominal_err_total",  ill_seen + seq_seen + dur_seen, 0);
      chk("nominal_sticky",     sticky_o, 0);

      // Illegal encoding during P0, then relock
      begin_scn("illegal");
      run(0, 3);
      tick(3'b001, 3'b001);
      run(0, 5); run(1, 3); run(2, 8); run(3, 3); run(0, 2);
      end_scn();
      chk("illegal_ill_total", ill_seen, 1);
      chk("illegal_dur_total", dur_seen, 0);
      chk("illegal_count",     cnt_o, (CNT_ON == 1) ? 1 : 0);

      // Skipped phase P0 -> P2
      begin_scn("skip");
      run(0, 4); run(1, 3); run(2, 8); run(3, 3);
      run(0, 8); run(2, 8); run(3, 3); run(0, 1);
      end_scn();
      chk("skip_seq_total", seq_seen, 1);
      chk("skip_dur_total", dur_seen, 0);

      // Understay of P1, overstay of P2
      begin_scn("duration");
      run(0, 5); run(1, 3); run(2, 8); run(3, 3);
      run(0, 8); run(1, 2); run(2, 11); run(3, 3); run(0, 1);
      end_scn();
      chk("duration_dur_total", dur_seen, 2);
      chk("duration_seq_total", seq_seen, 0);

      // Reset in the middle of P0
      begin_scn("midreset");
      run(0, 5); run(1, 3); run(2, 8); run(3, 3); run(0, 4);
      reset_on();
      hold_reset(2);
      run(0, 4); run(1, 3); run(2, 8); run(3, 3); run(0, 1);
      end_scn();
      chk("midreset_err_total",  ill_seen + seq_seen + dur_seen, 0);
      chk("midreset_done_total", done_seen, 2);
      chk("midreset_sticky",     sticky_o, 0);

      // Five consecutive illegal samples
      begin_scn("saturate");
      run(0, 2);
      repeat (5) tick(3'b011, 3'b100);
      end_scn();
      chk("sat_ill_total", ill_seen, 5);
      chk("sat_count_w2",  s_cnt, (CNT_ON == 1) ? 3 : 0);
      chk("sat_count_w8",  cnt_o, (CNT_ON == 1) ? 5 : 0);
      chk("sat_sticky",    sticky_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
